pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Registered program-counter sequencer for the 32-bit MIPS datapath, and the parametrised successor to the combinational jump-address former. It holds the PC and selects the next PC each cycle from five sources: sequential, branch, J/JAL pseudo-direct, JR register, or return-stack pop. Unlike the old block, it forms the architecturally correct jump target by concatenating the upper PC+4 bits with the word-aligned target instead of zero-extending. It sits between the control unit and instruction memory, and supplies the PC, PC+4 and the link address to the datapath.

## Interface
- ADDR_W, 32, PC width; must satisfy ADDR_W ≥ TGT_W+2
- TGT_W, 26, J-format target field width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2); used only with PC_SEQ_RAS_EN

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC and all state this cycle
- branch_taken  in  1  take branch target
- branch_offset  in  16  signed word offset (I-format immediate)
- jump  in  1  J: pseudo-direct jump
- jal  in  1  JAL: pseudo-direct jump and link
- target_address  in  TGT_W  J-format target field
- jr  in  1  jump to register
- jr_addr  in  ADDR_W  register value for JR
- ret  in  1  return: pop RAS (JR $ra hint from decode)
- pc  out  ADDR_W  current PC (registered)
- pc_plus4  out  ADDR_W  pc+4, combinational
- link_addr  out  ADDR_W  equals pc_plus4; written to $ra on JAL
- misaligned  out  1  registered one-cycle pulse: JR address had bits [1:0]≠0
- ras_overflow  out  1  registered one-cycle pulse: push onto a full RAS
- ras_underflow  out  1  registered one-cycle pulse: pop from an empty RAS

## Operation
- All arithmetic is modulo 2^ADDR_W. Wrap-around from all-ones to 0 is legal and silent.
- Jump target: {pc_plus4[ADDR_W-1:TGT_W+2], target_address, 2'b00}.
- Branch target: pc_plus4 + (sign_extend(branch_offset) << 2).
- JR target: {jr_addr[ADDR_W-1:2], 2'b00}. If jr_addr[1:0]≠0, misaligned pulses on the next cycle.
- Next-PC priority, highest first: jr, ret, jump/jal, branch_taken, sequential (pc_plus4).
  - A lower-priority request asserted together with a higher one is dropped. It has no side effects: no push and no flag.
- jal pushes link_addr onto the RAS only when jal wins priority.
- With stall=1, the block holds pc, RAS contents, RAS count and pointer. All flags are forced to 0 on that edge.
- RAS behaviour:
  - Implemented as a circular buffer with a top pointer and a count that saturates at RAS_DEPTH.
  - Push when full: overwrites the oldest entry, count stays at RAS_DEPTH, ras_overflow pulses.
  - Pop when count=0: next PC is pc_plus4, pointer and count are unchanged, ras_underflow pulses.
  - Pop when non-empty: next PC is the top entry, count decrements.

## Timing
- pc, flags and RAS state update on the rising edge of clk.
- pc_plus4 and link_addr are combinational from pc.
- Control inputs are sampled at the edge. The selected target appears on pc one cycle later: zero-bubble redirect.
- Flags are registered and high for exactly one cycle after the causing edge.
- Reset (asynchronous, mid-operation included) sets:
  - pc=RESET_PC
  - misaligned=0, ras_overflow=0, ras_underflow=0
  - RAS count=0 and pointer=0
  - RAS entry contents are don't-care.
- On release of rst_n, the first edge with stall=0 advances to RESET_PC+4 unless a redirect is requested.

## Configuration
- PC_SEQ_RAS_EN defined:
  - RAS is built with RAS_DEPTH entries.
  - ret pops as described above.
  - ras_overflow and ras_underflow are live.
- PC_SEQ_RAS_EN undefined:
  - No RAS storage.
  - ret is ignored: priority falls through to the next asserted request, or to sequential.
  - jal performs the jump only.
  - ras_overflow and ras_underflow are tied to 0.

## Test plan
- Reset then 3 unstalled cycles -> pc = 0, 4, 8, 0xC. Assert rst_n=0 asynchronously mid-cycle -> pc=0 immediately.
- pc=0x4000_0010, jump=1, target_address=26'h0000100 -> next pc=0x4000_0400. Upper nibble comes from pc_plus4, not zero.
- pc=0x0000_0100, branch_taken=1, offset=16'hFFFE -> next pc=0x0000_00FC. With jr=1, jr_addr=0x0000_2003 in the same cycle -> pc=0x0000_2000 and misaligned=1 for one cycle.
- pc=0xFFFF_FFFC, sequential -> pc=0x0000_0000 with no flag. stall=1 for 3 cycles with jump=1 -> pc holds and no push occurs.
- PC_SEQ_RAS_EN, RAS_DEPTH=4:
  - 5 consecutive jal pushes -> ras_overflow pulses on the 5th.
  - 4 ret -> pcs equal link addresses 5, 4, 3, 2 in order.
  - 5th ret -> pc=pc_plus4 and ras_underflow=1.
- PC_SEQ_RAS_EN undefined: ret=1 with branch_taken=1 -> branch target is taken and both RAS flags stay 0.

Source files
------------

// File: rtl/pc_seq_if.sv
// pc_seq_if: control requests from decode and PC/flag outputs of pc_sequencer.
interface pc_seq_if #(
    parameter int ADDR_W = 32,
    parameter int TGT_W  = 26
);
    logic              stall;
    logic              branch_taken;
    logic [15:0]       branch_offset;
    logic              jump;
    logic              jal;
    logic [TGT_W-1:0]  target_address;
    logic              jr;
    logic [ADDR_W-1:0] jr_addr;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] link_addr;
    logic              misaligned;
    logic              ras_overflow;
    logic              ras_underflow;

    modport master (
        output stall, branch_taken, branch_offset, jump, jal, target_address, jr, jr_addr, ret,
        input  pc, pc_plus4, link_addr, misaligned, ras_overflow, ras_underflow
    );
    modport slave (
        input  stall, branch_taken, branch_offset, jump, jal, target_address, jr, jr_addr, ret,
        output pc, pc_plus4, link_addr, misaligned, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered MIPS PC with branch/J/JAL/JR/return next-PC selection.
// Define PC_SEQ_RAS_EN to build the return-address stack (ret pops, jal pushes).
module pc_sequencer #(
    parameter int              ADDR_W    = 32,
    parameter int              TGT_W     = 26,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    pc_seq_if.slave   bus
);
    logic [ADDR_W-1:0] pc, pc_plus4, br_tgt, j_tgt, jr_tgt, ret_tgt, nxt;
    logic ret_win, jmp_win, push, mis_r, ovf_r, unf_r;

    assign pc_plus4 = pc + ADDR_W'(4);
    assign br_tgt   = pc_plus4 + {{(ADDR_W-18){bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    // Keep the region bits of pc+4 above the target field; shifting also covers ADDR_W == TGT_W+2
    assign j_tgt    = ((pc_plus4 >> (TGT_W + 2)) << (TGT_W + 2)) | ADDR_W'({bus.target_address, 2'b00});
    assign jr_tgt   = {bus.jr_addr[ADDR_W-1:2], 2'b00};
    assign jmp_win  = !bus.jr && !ret_win && (bus.jump || bus.jal);
    assign push     = jmp_win && bus.jal;
    assign nxt      = bus.jr ? jr_tgt :
                      ret_win ? ret_tgt :
                      (bus.jump || bus.jal) ? j_tgt :
                      bus.branch_taken ? br_tgt : pc_plus4;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc    <= RESET_PC;
            mis_r <= 1'b0;
        end else if (bus.stall) begin
            mis_r <= 1'b0;
        end else begin
            pc    <= nxt;
            mis_r <= bus.jr && (bus.jr_addr[1:0] != 2'b00);
        end

`ifdef PC_SEQ_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0] top;
    logic [PW:0] cnt;
    logic empty, full;

    assign empty   = cnt == '0;
    assign full    = cnt == (PW+1)'(RAS_DEPTH);
    assign ret_win = !bus.jr && bus.ret;
    assign ret_tgt = empty ? pc_plus4 : ras[top];

    // Entries carry no reset; count and pointer alone define validity
    always_ff @(posedge clk)
        if (!bus.stall && push) ras[top + 1'b1] <= pc_plus4;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            top   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (bus.stall) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            ovf_r <= push && full;
            unf_r <= ret_win && empty;
            if (push) begin
                top <= top + 1'b1;
                cnt <= full ? cnt : cnt + 1'b1;
            end else if (ret_win && !empty) begin
                top <= top - 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
`else
    logic unused_ras;
    assign unused_ras = bus.ret ^ RAS_DEPTH[0];
    assign ret_win    = 1'b0;
    assign ret_tgt    = pc_plus4;
    assign ovf_r      = 1'b0;
    assign unf_r      = 1'b0;
`endif

    assign bus.pc            = pc;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.link_addr     = pc_plus4;
    assign bus.misaligned    = mis_r;
    assign bus.ras_overflow  = ovf_r;
    assign bus.ras_underflow = unf_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of reset, jumps, branches, JR, wrap, stall and RAS handling.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    pc_seq_if #(.ADDR_W(32), .TGT_W(26)) bus();
    pc_sequencer #(.ADDR_W(32), .TGT_W(26), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bus.stall = 0; bus.branch_taken = 0; bus.branch_offset = 16'h0; bus.jump = 0; bus.jal = 0;
        bus.target_address = 26'h0; bus.jr = 0; bus.jr_addr = 32'h0; bus.ret = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [31:0] a);
        bus.jr = 1; bus.jr_addr = a;
        tick();
        bus.jr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        #3;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=%h", bus.pc, 32'h0); end
        checks++; if (bus.pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_plus4 got=%h exp=%h", bus.pc_plus4, 32'h4); end
        checks++; if (bus.link_addr !== 32'h4) begin errors++; $display("FAIL rst_link got=%h exp=%h", bus.link_addr, 32'h4); end
        checks++; if ({bus.misaligned, bus.ras_overflow, bus.ras_underflow} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus.misaligned, bus.ras_overflow, bus.ras_underflow}); end
        @(negedge clk); rst_n = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.pc, 32'(i * 4)); end
        end
        #2; rst_n = 0; #1;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL async_rst_pc got=%h exp=%h", bus.pc, 32'h0); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_jump();
        goto(32'h4000_0010);
        checks++; if (bus.pc !== 32'h4000_0010) begin errors++; $display("FAIL jr_setup got=%h exp=%h", bus.pc, 32'h4000_0010); end
        bus.jump = 1; bus.target_address = 26'h0000100;
        tick();
        bus.jump = 0;
        checks++; if (bus.pc !== 32'h4000_0400) begin errors++; $display("FAIL jump_pc got=%h exp=%h", bus.pc, 32'h4000_0400); end
        checks++; if (bus.link_addr !== 32'h4000_0404) begin errors++; $display("FAIL link_addr got=%h exp=%h", bus.link_addr, 32'h4000_0404); end
        bus.jal = 1; bus.target_address = 26'h0000003;
        tick();
        bus.jal = 0;
        checks++; if (bus.pc !== 32'h4000_000C) begin errors++; $display("FAIL jal_pc got=%h exp=%h", bus.pc, 32'h4000_000C); end
    endtask

    task automatic test_branch();
        goto(32'h0000_0100);
        bus.branch_taken = 1; bus.branch_offset = 16'hFFFE;
        tick();
        checks++; if (bus.pc !== 32'h0000_00FC) begin errors++; $display("FAIL br_neg got=%h exp=%h", bus.pc, 32'h0000_00FC); end
        bus.branch_offset = 16'h0004;
        tick();
        checks++; if (bus.pc !== 32'h0000_0110) begin errors++; $display("FAIL br_pos got=%h exp=%h", bus.pc, 32'h0000_0110); end
        bus.jr = 1; bus.jr_addr = 32'h0000_2003;
        tick();
        idle();
        checks++; if (bus.pc !== 32'h0000_2000) begin errors++; $display("FAIL jr_over_br got=%h exp=%h", bus.pc, 32'h0000_2000); end
        checks++; if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse got=%b exp=1", bus.misaligned); end
        tick();
        checks++; if (bus.pc !== 32'h0000_2004) begin errors++; $display("FAIL after_jr got=%h exp=%h", bus.pc, 32'h0000_2004); end
        checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b exp=0", bus.misaligned); end
        bus.jump = 1; bus.target_address = 26'h10; bus.branch_taken = 1; bus.branch_offset = 16'h0100;
        tick();
        idle();
        checks++; if (bus.pc !== 32'h0000_0040) begin errors++; $display("FAIL jump_over_br got=%h exp=%h", bus.pc, 32'h0000_0040); end
    endtask

    task automatic test_wrap_stall();
        goto(32'hFFFF_FFFC);
        checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got=%h exp=%h", bus.pc_plus4, 32'h0); end
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, 32'h0); end
        checks++; if ({bus.misaligned, bus.ras_overflow, bus.ras_underflow} !== 3'b000) begin errors++; $display("FAIL wrap_flags got=%b exp=000", {bus.misaligned, bus.ras_overflow, bus.ras_underflow}); end
        bus.stall = 1; bus.jump = 1; bus.target_address = 26'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, bus.pc, 32'h0); end
        end
        idle();
        bus.stall = 1; bus.jr = 1; bus.jr_addr = 32'h0000_0013;
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL stall_jr_pc got=%h exp=%h", bus.pc, 32'h0); end
        checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL stall_mis got=%b exp=0", bus.misaligned); end
        idle();
        tick();
        checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL unstall_pc got=%h exp=%h", bus.pc, 32'h4); end
    endtask

`ifdef PC_SEQ_RAS_EN
    task automatic test_ras();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h1004; exp_ret[1] = 32'h0C04; exp_ret[2] = 32'h0804; exp_ret[3] = 32'h0404;
        rst_n = 0; idle(); #1;
        @(negedge clk); rst_n = 1;
        goto(32'h0000_0100);
        bus.stall = 1; bus.jal = 1; bus.target_address = 26'h40;
        for (int i = 0; i < 3; i++) tick();
        idle();
        bus.ret = 1;
        tick();
        bus.ret = 0;
        checks++; if (bus.pc !== 32'h0000_0104) begin errors++; $display("FAIL stall_nopush_pc got=%h exp=%h", bus.pc, 32'h0000_0104); end
        checks++; if (bus.ras_underflow !== 1'b1) begin errors++; $display("FAIL stall_nopush_unf got=%b exp=1", bus.ras_underflow); end
        goto(32'h0000_0100);
        for (int i = 1; i <= 5; i++) begin
            bus.jal = 1; bus.target_address = 26'(i * 256);
            tick();
            checks++; if (bus.pc !== 32'(i * 32'h400)) begin errors++; $display("FAIL push%0d_pc got=%h exp=%h", i, bus.pc, 32'(i * 32'h400)); end
            checks++; if (bus.ras_overflow !== (i == 5)) begin errors++; $display("FAIL push%0d_ovf got=%b exp=%b", i, bus.ras_overflow, (i == 5)); end
        end
        idle();
        bus.ret = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.pc !== exp_ret[k]) begin errors++; $display("FAIL pop%0d_pc got=%h exp=%h", k, bus.pc, exp_ret[k]); end
            checks++; if (bus.ras_underflow !== 1'b0) begin errors++; $display("FAIL pop%0d_unf got=%b exp=0", k, bus.ras_underflow); end
        end
        tick();
        bus.ret = 0;
        checks++; if (bus.pc !== 32'h0408) begin errors++; $display("FAIL pop_empty_pc got=%h exp=%h", bus.pc, 32'h0408); end
        checks++; if (bus.ras_underflow !== 1'b1) begin errors++; $display("FAIL pop_empty_unf got=%b exp=1", bus.ras_underflow); end
        tick();
        checks++; if (bus.ras_underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", bus.ras_underflow); end
    endtask
`else
    task automatic test_ret_ignored();
        goto(32'h0000_0300);
        bus.ret = 1; bus.branch_taken = 1; bus.branch_offset = 16'h0004;
        tick();
        bus.branch_taken = 0;
        checks++; if (bus.pc !== 32'h0000_0314) begin errors++; $display("FAIL ret_br_pc got=%h exp=%h", bus.pc, 32'h0000_0314); end
        checks++; if ({bus.ras_overflow, bus.ras_underflow} !== 2'b00) begin errors++; $display("FAIL ret_br_flags got=%b exp=00", {bus.ras_overflow, bus.ras_underflow}); end
        tick();
        bus.ret = 0;
        checks++; if (bus.pc !== 32'h0000_0318) begin errors++; $display("FAIL ret_seq_pc got=%h exp=%h", bus.pc, 32'h0000_0318); end
        checks++; if (bus.ras_underflow !== 1'b0) begin errors++; $display("FAIL ret_seq_unf got=%b exp=0", bus.ras_underflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_wrap_stall();
`ifdef PC_SEQ_RAS_EN
        test_ras();
`else
        test_ret_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
